// File: rtl/multicycle_control_fsm.sv
// Main controller for the multicycle RV32I datapath.
// Decodes the instruction-register fields and runs each instruction through
// fetch, decode, execute, memory and writeback. Every cycle it drives the
// datapath mux selects, the write enables and the 2-bit ALUControl
// (00 add, 01 sub, 10 and, 11 or).
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   op          instruction[6:0]
//   funct3      instruction[14:12]
//   funct7b5    instruction[30]
//   Zero        ALU result == 0, combinational from the current ALU operation
//   PCWrite     PC register enable
//   AdrSrc      memory address select: 0 PC, 1 ALU result register
//   MemWrite    data memory write enable
//   IRWrite     instruction register (and OldPC) enable
//   ResultSrc   result mux: 00 ALUOut, 01 read data, 10 ALUResult
//   ALUSrcA     00 PC, 01 OldPC, 10 register A
//   ALUSrcB     00 register B, 01 ImmExt, 10 constant 4
//   ImmSrc      00 I, 01 S, 10 B, 11 J
//   ALUControl  00 add, 01 sub, 10 and, 11 or
//   RegWrite    register file write enable
//   Illegal     one-cycle pulse when an unsupported instruction is decoded
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUControl,
    output logic       RegWrite,
    output logic       Illegal
);

    localparam int unsigned OP_W = 7;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       pc_update;
    logic       branch;
    logic [1:0] alu_op;
    logic       mem_we;
    logic       ir_we;
    logic       reg_we;
    logic       illegal_dec;
    logic       funct3_ok;

    // State register; reset always returns to Fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Only add/sub, and, or are implemented for R- and I-type
    assign funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);

    // Next-state and per-state Moore controls
    always_comb begin
        state_next  = S_FETCH;
        pc_update   = 1'b0;
        branch      = 1'b0;
        alu_op      = 2'b00;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        reg_we      = 1'b0;
        illegal_dec = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;

        case (state)
            S_FETCH: begin
                ir_we      = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                pc_update  = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                // Branch target precompute: OldPC + ImmExt
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                if (op == OP_LW || op == OP_SW) begin
                    state_next = S_MEMADR;
                end else if (op == OP_R && funct3_ok) begin
                    state_next = S_EXECR;
                end else if (op == OP_I && funct3_ok) begin
                    state_next = S_EXECI;
                end else if (op == OP_BEQ && funct3 == 3'b000) begin
                    state_next = S_BEQ;
                end else if (op == OP_JAL) begin
                    state_next = S_JAL;
                end else begin
                    illegal_dec = 1'b1;
                    state_next  = S_FETCH;
                end
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                reg_we     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                mem_we     = 1'b1;
                state_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we     = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b01;
                branch     = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // ALU computes OldPC + 4 for the link register
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // ALU decode from the current state's ALUOp and the funct fields
    always_comb begin
        ALUControl = 2'b00;
        case (alu_op)
            2'b01: ALUControl = 2'b01;
            2'b10: begin
                case (funct3)
                    // Subtract only for R-type; addi ignores funct7b5
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 2'b01 : 2'b00;
                    3'b111:  ALUControl = 2'b10;
                    3'b110:  ALUControl = 2'b11;
                    default: ALUControl = 2'b00;
                endcase
            end
            default: ALUControl = 2'b00;
        endcase
    end

    // Immediate format depends only on the opcode
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Write enables are suppressed during reset so an aborted instruction
    // leaves no partial update behind
    always_comb begin
        PCWrite  = ~reset & (pc_update | (branch & Zero));
        IRWrite  = ~reset & ir_we;
        MemWrite = ~reset & mem_we;
        RegWrite = ~reset & reg_we;
        Illegal  = ~reset & illegal_dec;
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. Each scoreboard entry carries
// the inputs for one clock cycle and the output vector expected in it.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [1:0] ALUControl;
    logic       RegWrite;
    logic       Illegal;

    multicycle_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .Illegal    (Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
    //  ImmSrc, ALUControl, RegWrite, Illegal}
    logic [15:0] obs;
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, ALUControl, RegWrite, Illegal};

    localparam logic [15:0] EN_BITS = 16'hB003;
    localparam logic [15:0] ALL     = 16'hFFFF;
    localparam int unsigned TIMEOUT_CYCLES = 2000;

    typedef struct {
        string       tag;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        zero;
        logic        rst;
        logic [15:0] mask;
        logic [15:0] exp;
    } entry_t;

    entry_t     sbq[$];
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7;
    int         n_checks;
    int         n_fails;

    function automatic logic [15:0] ov(input logic pcw, input logic adr, input logic memw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] imm, input logic [1:0] alu,
                                       input logic rw, input logic ill);
        return {pcw, adr, memw, irw, rs, sa, sb, imm, alu, rw, ill};
    endfunction

    // Expected output vectors of each state, written out from the state table
    function automatic logic [15:0] e_fetch(input logic [1:0] imm);
        return ov(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 2'b00, 0, 0);
    endfunction
    function automatic logic [15:0] e_decode(input logic [1:0] imm, input logic ill);
        return ov(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 2'b00, 0, ill);
    endfunction
    function automatic logic [15:0] e_memadr(input logic [1:0] imm);
        return ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 2'b00, 0, 0);
    endfunction
    function automatic logic [15:0] e_memread();
        return ov(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
    endfunction
    function automatic logic [15:0] e_memwb();
        return ov(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0);
    endfunction
    function automatic logic [15:0] e_memwrite();
        return ov(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0);
    endfunction
    function automatic logic [15:0] e_execr(input logic [1:0] alu);
        return ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 0, 0);
    endfunction
    function automatic logic [15:0] e_execi(input logic [1:0] alu);
        return ov(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 0, 0);
    endfunction
    function automatic logic [15:0] e_aluwb(input logic [1:0] imm);
        return ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 2'b00, 1, 0);
    endfunction
    function automatic logic [15:0] e_beq(input logic taken);
        return ov(taken, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 0, 0);
    endfunction
    function automatic logic [15:0] e_jal();
        return ov(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 0, 0);
    endfunction

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        cur_op = o;
        cur_f3 = f3;
        cur_f7 = f7;
    endtask

    task automatic push(input string tag, input logic [15:0] exp, input logic zero = 1'b0,
                        input logic rst = 1'b0, input logic [15:0] mask = ALL);
        entry_t e;
        e.tag  = tag;
        e.op   = cur_op;
        e.f3   = cur_f3;
        e.f7   = cur_f7;
        e.zero = zero;
        e.rst  = rst;
        e.mask = mask;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    // Watchdog: the run must finish within a bounded number of cycles
    initial begin
        repeat (TIMEOUT_CYCLES) @(posedge clk);
        $error("FAIL timeout: test did not finish within %0d cycles", TIMEOUT_CYCLES);
        $finish;
    end

    initial begin
        entry_t e;
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        op       = 7'b0;
        funct3   = 3'b0;
        funct7b5 = 1'b0;
        Zero     = 1'b0;

        // Reset from an unknown state: only the enables are defined
        instr(7'b0110011, 3'b000, 1'b1);
        push("rst_init", 16'h0000, 0, 1, EN_BITS);
        push("rst_fetch", e_fetch(2'b00));
        push("r_dec0", e_decode(2'b00, 0));
        // Reset held 3 cycles, starting in ExecuteR
        push("rst_execr", e_execr(2'b01), 0, 1);
        push("rst_fetch_a", e_fetch(2'b00) & ~EN_BITS, 0, 1);
        push("rst_fetch_b", e_fetch(2'b00) & ~EN_BITS, 1, 1);
        // R-type sub
        push("sub_fetch", e_fetch(2'b00));
        push("sub_dec", e_decode(2'b00, 0));
        push("sub_exec", e_execr(2'b01));
        push("sub_wb", e_aluwb(2'b00));
        // R-type add
        instr(7'b0110011, 3'b000, 1'b0);
        push("add_fetch", e_fetch(2'b00));
        push("add_dec", e_decode(2'b00, 0));
        push("add_exec", e_execr(2'b00));
        push("add_wb", e_aluwb(2'b00));
        // R-type and
        instr(7'b0110011, 3'b111, 1'b0);
        push("and_fetch", e_fetch(2'b00));
        push("and_dec", e_decode(2'b00, 0));
        push("and_exec", e_execr(2'b10), 1);
        push("and_wb", e_aluwb(2'b00), 1);
        // R-type or, Zero high where it must be ignored
        instr(7'b0110011, 3'b110, 1'b1);
        push("or_fetch", e_fetch(2'b00), 1);
        push("or_dec", e_decode(2'b00, 0), 1);
        push("or_exec", e_execr(2'b11), 1);
        push("or_wb", e_aluwb(2'b00), 1);
        // addi with funct7b5 set still adds
        instr(7'b0010011, 3'b000, 1'b1);
        push("addi_fetch", e_fetch(2'b00));
        push("addi_dec", e_decode(2'b00, 0));
        push("addi_exec", e_execi(2'b00));
        push("addi_wb", e_aluwb(2'b00));
        // ori
        instr(7'b0010011, 3'b110, 1'b0);
        push("ori_fetch", e_fetch(2'b00));
        push("ori_dec", e_decode(2'b00, 0));
        push("ori_exec", e_execi(2'b11));
        push("ori_wb", e_aluwb(2'b00));
        // lw: 5 cycles
        instr(7'b0000011, 3'b010, 1'b0);
        push("lw_fetch", e_fetch(2'b00));
        push("lw_dec", e_decode(2'b00, 0));
        push("lw_adr", e_memadr(2'b00), 1);
        push("lw_read", e_memread(), 1);
        push("lw_wb", e_memwb());
        // sw: 4 cycles
        instr(7'b0100011, 3'b010, 1'b0);
        push("sw_fetch", e_fetch(2'b01));
        push("sw_dec", e_decode(2'b01, 0));
        push("sw_adr", e_memadr(2'b01));
        push("sw_write", e_memwrite(), 1);
        // beq taken
        instr(7'b1100011, 3'b000, 1'b0);
        push("beqt_fetch", e_fetch(2'b10), 1);
        push("beqt_dec", e_decode(2'b10, 0), 1);
        push("beqt_beq", e_beq(1), 1);
        // beq not taken
        push("beqn_fetch", e_fetch(2'b10));
        push("beqn_dec", e_decode(2'b10, 0), 1);
        push("beqn_beq", e_beq(0), 0);
        // Illegal: I-type with funct3=010
        instr(7'b0010011, 3'b010, 1'b0);
        push("ill_i_fetch", e_fetch(2'b00));
        push("ill_i_dec", e_decode(2'b00, 1), 1);
        // Illegal: op 0000000
        instr(7'b0000000, 3'b000, 1'b0);
        push("ill_z_fetch", e_fetch(2'b00));
        push("ill_z_dec", e_decode(2'b00, 1));
        // Illegal: branch opcode with funct3 other than 000
        instr(7'b1100011, 3'b001, 1'b0);
        push("ill_b_fetch", e_fetch(2'b10));
        push("ill_b_dec", e_decode(2'b10, 1), 1);
        // sw aborted by reset in MemWrite
        instr(7'b0100011, 3'b010, 1'b0);
        push("swr_fetch", e_fetch(2'b01));
        push("swr_dec", e_decode(2'b01, 0));
        push("swr_adr", e_memadr(2'b01));
        push("swr_write_rst", e_memwrite() & ~EN_BITS, 0, 1);
        push("swr_refetch", e_fetch(2'b01));
        push("swr_dec2", e_decode(2'b01, 0));
        push("swr_adr2", e_memadr(2'b01));
        push("swr_write2", e_memwrite());
        // jal: 4 cycles, ImmSrc=11 throughout
        instr(7'b1101111, 3'b000, 1'b0);
        push("jal_fetch", e_fetch(2'b11));
        push("jal_dec", e_decode(2'b11, 0));
        push("jal_jal", e_jal());
        push("jal_wb", e_aluwb(2'b11), 1);
        push("jal_next", e_fetch(2'b11));

        // Drive each entry for one cycle and check it mid-cycle
        while (sbq.size() > 0) begin
            e        = sbq.pop_front();
            reset    = e.rst;
            op       = e.op;
            funct3   = e.f3;
            funct7b5 = e.f7;
            Zero     = e.zero;
            @(negedge clk);
            n_checks++;
            assert ((obs & e.mask) === (e.exp & e.mask))
            else begin
                n_fails++;
                $error("FAIL %s: observed %h expected %h (mask %h)",
                       e.tag, obs & e.mask, e.exp & e.mask, e.mask);
            end
            @(posedge clk);
            #1;
        end

        // Reset asserted mid-flight: all write enables must be forced low
        reset = 1'b1;
        Zero  = 1'b1;
        @(negedge clk);
        n_checks++;
        if ((obs & EN_BITS) !== 16'h0000) begin
            n_fails++;
            $error("FAIL reset_state: enables observed %h expected 0000", obs & EN_BITS);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        Zero  = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main controller for the multicycle RV32I datapath. It decodes the instruction-register fields and sequences fetch, decode, execute, memory and writeback. Each cycle it drives the datapath mux selects and write enables, including the 2-bit ALUControl consumed by the ALU (00 add, 01 sub, 10 and, 11 or). It is the producer end of that ALU control interface.

Parameters:
None.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
op  input  7  instruction[6:0] from the instruction register
funct3  input  3  instruction[14:12]
funct7b5  input  1  instruction[30]
Zero  input  1  ALU result == 0; combinational from the current ALU operation
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register (and OldPC) enable
ResultSrc  output  2  result mux: 00 ALUOut, 01 read data, 10 ALUResult
ALUSrcA  output  2  00 PC, 01 OldPC, 10 register A
ALUSrcB  output  2  00 register B, 01 ImmExt, 10 constant 4
ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
ALUControl  output  2  00 add, 01 sub, 10 and, 11 or
RegWrite  output  1  register file write enable
Illegal  output  1  one-cycle pulse when an unsupported instruction is decoded

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. The state register loads Fetch on the rising clk edge while reset=1.
- While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and Illegal are forced to 0 regardless of state. All other outputs are 0 after reset, except the Fetch-state values listed below.
- Reset asserted mid-instruction aborts it. The next state is Fetch and no partial write occurs in the reset cycle.
- Outputs are Moore, decoded from the state register, except for three signals:
  - PCWrite = PCUpdate | (Branch & Zero).
  - ImmSrc is decoded from op only.
  - ALUControl is decoded from the ALUOp of the current state plus funct fields.
- Signals not listed for a state are 0.
- States and outputs:
  - Fetch: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
  - Decode: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target precompute).
  - MemAdr: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MemRead: AdrSrc=1, ResultSrc=00.
  - MemWB: ResultSrc=01, RegWrite=1.
  - MemWrite: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - ExecuteR: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- Transitions:
  - Fetch -> Decode.
  - Decode -> MemAdr for lw (0000011) or sw (0100011).
  - Decode -> ExecuteR for 0110011.
  - Decode -> ExecuteI for 0010011.
  - Decode -> BEQ for 1100011 with funct3=000.
  - Decode -> JAL for 1101111.
  - Decode -> Fetch for anything else, with Illegal=1 during that Decode cycle.
  - MemAdr -> MemRead (lw) or MemWrite (sw). MemRead -> MemWB -> Fetch. MemWrite -> Fetch.
  - ExecuteR / ExecuteI -> ALUWB -> Fetch. BEQ -> Fetch. JAL -> ALUWB.
- Supported funct3 in Decode for R/I-type: 000, 110, 111. Any other funct3 counts as illegal.
- ALU decode:
  - ALUOp 00 -> ALUControl 00.
  - ALUOp 01 -> ALUControl 01.
  - ALUOp 10, funct3=000: ALUControl 01 if op[5]&funct7b5 (R-type sub), else 00. I-type addi ignores funct7b5.
  - ALUOp 10, funct3=111 -> 10; funct3=110 -> 11.
- ImmSrc by op:
  - sw -> 01; beq -> 10; jal -> 11.
  - All other op values -> 00.
- Latency in cycles from Fetch, inclusive: lw 5, sw 4, R 4, I 4, beq 3, jal 4, illegal 2.
- op, funct3 and funct7b5 must be stable from Decode until the return to Fetch; the IR only updates in Fetch.
- Zero is sampled only in BEQ.

Test Plan:
- Hold reset=1 for 3 cycles in an arbitrary state -> PCWrite=IRWrite=RegWrite=MemWrite=0. After release, first cycle shows Fetch outputs: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- op=0000011 (lw) -> states Fetch, Decode, MemAdr, MemRead, MemWB. AdrSrc=1 in MemRead; RegWrite=1 and ResultSrc=01 only in MemWB; 5 cycles total.
- op=0110011, funct3=000, funct7b5=1 -> ExecuteR with ALUControl=01. Repeat with funct7b5=0 -> 00. With funct3=111 -> 10 and funct3=110 -> 11. ALUWB asserts RegWrite for exactly one cycle.
- op=1100011, funct3=000: Zero=1 in BEQ -> PCWrite=1, ALUControl=01. Zero=0 -> PCWrite=0. Both return to Fetch after 3 cycles; Zero toggling in other states never raises PCWrite.
- op=0010011, funct3=010, and op=0000000 -> Illegal=1 for exactly the Decode cycle, next state Fetch, no RegWrite/MemWrite.
- sw in the MemWrite state with reset=1 -> MemWrite=0 that cycle, next state Fetch. jal sequence Fetch, Decode, JAL (PCWrite=1, ALUSrcA=01, ALUSrcB=10), ALUWB, with ImmSrc=11 throughout.
